rename_table_multi: RTL and testbench
=====================================

Name: rename_table_multi

Overview:
Parametrised successor to the single-port rename table in decode_issue. It supports:
- multiple allocation ports, multiple lookup ports, multiple complete ports and multiple commit ports;
- a committed (architectural) map;
- a one-cycle squash that restores the speculative map and rebuilds the free list from the committed state.

It sits between decode and issue. Lookups feed operand readiness; allocations rename destinations.

Parameters:
p_num_phys_regs, 36, total physical registers; must be > 32 + p_num_alloc
p_num_alloc, 2, allocation ports per cycle; port 0 is oldest
p_num_lookup, 4, combinational lookup ports
p_num_complete, 2, complete notification ports
p_num_commit, 2, commit ports; port 0 is oldest

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset; state initialises on the clk edge while rst==0
alloc_areg[p_num_alloc]  input  5  destination arch reg
alloc_en[p_num_alloc]  input  1  allocation fires this cycle
alloc_rdy[p_num_alloc]  output  1  port may allocate
alloc_preg[p_num_alloc]  output  PB  new physical reg (PB = $clog2(p_num_phys_regs))
alloc_ppreg[p_num_alloc]  output  PB  previous mapping of areg
lookup_areg[p_num_lookup]  input  5  source arch reg
lookup_preg[p_num_lookup]  output  PB  current mapping
lookup_pending[p_num_lookup]  output  1  value not yet produced
complete_val[p_num_complete]  input  1  preg result written
complete_preg[p_num_complete]  input  PB  completed preg
commit_val[p_num_commit]  input  1  instruction retires
commit_areg[p_num_commit]  input  5  retiring destination
commit_preg[p_num_commit]  input  PB  retiring preg (becomes architectural)
commit_ppreg[p_num_commit]  input  PB  preg freed by retirement
squash  input  1  flush all speculative state

Behaviour:
- Reset (rst==0 at edge):
  - spec_map[i] = arch_map[i] = i for i = 0..31; all pending = 0.
  - Free bits set for pregs 32..N-1.
  - Post-reset alloc_rdy[k] = 1 for all k.
- Outputs are combinational from registered state.
  - Lookups see state before this cycle's updates; there is no same-cycle alloc→lookup forwarding.
  - Lookup of areg 0 always returns preg 0, pending 0.
- Free-list selection:
  - Port k is offered the k-th lowest-indexed free preg.
  - alloc_rdy[k] = (free_count > k) && !squash.
  - alloc_en without rdy is a caller error (assertion in sim).
- Allocation with alloc_en[k]:
  - ppreg = spec_map[areg] as seen after ports 0..k-1 this cycle. Same-areg chains within one cycle are therefore honoured: port1.ppreg = port0.preg.
  - Next edge: spec_map[areg] = preg, pending[preg] = 1, preg removed from free list.
  - If a port takes k-th free but a lower port is not enabled, the assignment still holds. No compaction; fixed positions.
  - areg 0: returns preg 0 / ppreg 0 and consumes nothing. It still occupies its slot.
- Complete: at the edge, pending[complete_preg] = 0 for each valid port. Completion of a non-pending preg is a no-op.
- Commit, in port order:
  - arch_map[commit_areg] = commit_preg.
  - commit_ppreg is returned to the free list at the edge and is not allocatable until the following cycle.
  - commit_areg 0: ignored.
- Simultaneous events:
  - Complete and commit always apply.
  - Alloc and free never collide on the same preg.
  - If a complete and an alloc hit the same preg in one cycle, the alloc wins (pending = 1). This is illegal in normal use; assert.
- Squash (single-cycle, priority over alloc):
  - Same-cycle allocs are discarded; alloc_rdy is forced to 0.
  - At the edge: spec_map = arch_map', where arch_map' already includes same-cycle commits.
  - free = ~(union of pregs in arch_map'); all pending = 0.
  - Next cycle is fully usable.
- Reset mid-operation (rst low during squash or alloc): reset wins and the state returns to the reset values.
- Free count: popcount of free bits, width PB+1.

Optional Feature:
RENAME_TABLE_COMPLETE_BYPASS_EN
- Defined: lookup_pending is cleared combinationally when lookup_preg matches any valid complete_preg in the same cycle.
- Undefined: pending reflects registered state only, so there is a one-cycle later wakeup.

Decomposition:
- Package rename_pkg holds:
  - the arch register count constant (32);
  - the PB computation helper;
  - a typedef for the rename map entry;
  - alloc/commit message structs shared with the benches.
- One sub-module, rename_free_list:
  - holds the free bitvector;
  - does the k-lowest priority select;
  - holds the popcount;
  - handles the squash rebuild input.

Test Plan:
- Reset, then lookup areg 0..31 on all ports → preg = i, pending 0; alloc_rdy all 1.
- Same cycle, port0 alloc areg 3 and port1 alloc areg 3 (N=36) → port0 {preg 32, ppreg 3}, port1 {preg 33, ppreg 32}; next-cycle lookup 3 → 33 pending 1.
- Alloc areg 1 → 32; complete 32; lookup 1 → 32 pending 0 next cycle. With bypass macro defined, pending is 0 in the complete cycle.
- N=36: four allocs drain free list → alloc_rdy[0]=0. Commit ppreg 1 → rdy[0]=1 the cycle after, and alloc returns preg 1.
- Alloc areg 5 → 32, areg 6 → 33; commit areg 5 {preg 32, ppreg 5}; squash → lookup 5 → 32, lookup 6 → 6 pending 0; free = {5, 33, 34, 35}.
- Assert rst low during a squash cycle with allocs pending → full reset state; alloc of areg 0 → preg 0, ppreg 0, free count unchanged.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared definitions for the multi-port rename table: architectural register
// count, physical-register index width helper, map entry type and the
// alloc/commit message structs used by the table's environment.
package rename_pkg;

    localparam int ARCH_REGS = 32;
    localparam int AREG_W    = 5;

    // Width of a physical register index for a file of num_phys registers.
    function automatic int preg_bits(input int num_phys);
        return (num_phys > 1) ? $clog2(num_phys) : 1;
    endfunction

    localparam int DEFAULT_PHYS_REGS = 36;
    localparam int DEFAULT_PB        = preg_bits(DEFAULT_PHYS_REGS);

    typedef logic [AREG_W-1:0]     areg_t;
    typedef logic [DEFAULT_PB-1:0] map_entry_t;

    // One allocation request and the mapping it produces.
    typedef struct packed {
        logic       en;
        areg_t      areg;
        map_entry_t preg;
        map_entry_t ppreg;
    } alloc_msg_t;

    // One retiring instruction: areg now maps to preg, ppreg goes back to the pool.
    typedef struct packed {
        logic       val;
        areg_t      areg;
        map_entry_t preg;
        map_entry_t ppreg;
    } commit_msg_t;

endpackage

// File: rtl/rename_free_list.sv
// Free physical register pool: free bitvector, fixed-position k-lowest offer
// per allocation port, popcount, and wholesale rebuild on squash.
module rename_free_list
    import rename_pkg::*;
#(
    parameter int p_num_regs  = 36,
    parameter int p_num_offer = 2,
    parameter int p_pb        = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [p_num_offer-1:0] take,
    input  logic [p_num_regs-1:0] release_mask,
    input  logic                  squash,
    input  logic [p_num_regs-1:0] rebuild_mask,
    output logic [p_pb-1:0]       offer_preg [p_num_offer],
    output logic [p_pb:0]         free_count
);

    logic [p_num_regs-1:0] free_q;
    logic [p_num_regs-1:0] free_d;
    logic [p_num_regs-1:0] take_mask;

    // Port k is offered the k-th lowest free register; offers never compact.
    always_comb begin
        int found;
        found = 0;
        for (int k = 0; k < p_num_offer; k++) offer_preg[k] = '0;
        for (int i = 0; i < p_num_regs; i++) begin
            if (free_q[i]) begin
                for (int k = 0; k < p_num_offer; k++) begin
                    if (found == k) offer_preg[k] = p_pb'(i);
                end
                found = found + 1;
            end
        end
    end

    // Number of free registers, used by the table to derive per-port ready.
    always_comb begin
        free_count = '0;
        for (int i = 0; i < p_num_regs; i++) begin
            free_count = free_count + (p_pb+1)'(free_q[i]);
        end
    end

    // Next free vector: squash rebuilds from the committed map, otherwise
    // remove taken offers and add registers released by commit.
    always_comb begin
        take_mask = '0;
        for (int k = 0; k < p_num_offer; k++) begin
            if (take[k]) take_mask[offer_preg[k]] = 1'b1;
        end
        if (squash) free_d = rebuild_mask;
        else        free_d = (free_q & ~take_mask) | release_mask;
    end

    // Free vector register; registers above the architectural range start free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < p_num_regs; i++) free_q[i] <= (i >= ARCH_REGS);
        end else begin
            free_q <= free_d;
        end
    end

endmodule

// File: rtl/rename_table_multi.sv
// Multi-port register rename table with speculative and committed maps,
// per-preg pending bits and single-cycle squash recovery.
// Optional build macro RENAME_TABLE_COMPLETE_BYPASS_EN: when defined, a lookup
// whose preg is completing this cycle reports not-pending immediately.
// Handshake: an allocation fires on a cycle where alloc_en[k] and alloc_rdy[k]
// are both high; alloc_rdy is low during squash and alloc_en must not be raised
// on a not-ready port outside squash.
module rename_table_multi
    import rename_pkg::*;
#(
    parameter int p_num_phys_regs = 36,
    parameter int p_num_alloc     = 2,
    parameter int p_num_lookup    = 4,
    parameter int p_num_complete  = 2,
    parameter int p_num_commit    = 2,
    localparam int PB             = preg_bits(p_num_phys_regs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    alloc_areg     [p_num_alloc],
    input  logic          alloc_en       [p_num_alloc],
    output logic          alloc_rdy      [p_num_alloc],
    output logic [PB-1:0] alloc_preg     [p_num_alloc],
    output logic [PB-1:0] alloc_ppreg    [p_num_alloc],
    input  logic [4:0]    lookup_areg    [p_num_lookup],
    output logic [PB-1:0] lookup_preg    [p_num_lookup],
    output logic          lookup_pending [p_num_lookup],
    input  logic          complete_val   [p_num_complete],
    input  logic [PB-1:0] complete_preg  [p_num_complete],
    input  logic          commit_val     [p_num_commit],
    input  logic [4:0]    commit_areg    [p_num_commit],
    input  logic [PB-1:0] commit_preg    [p_num_commit],
    input  logic [PB-1:0] commit_ppreg   [p_num_commit],
    input  logic          squash
);

    logic [PB-1:0]              spec_map   [ARCH_REGS];
    logic [PB-1:0]              arch_map   [ARCH_REGS];
    logic [PB-1:0]              spec_chain [ARCH_REGS];
    logic [PB-1:0]              arch_next  [ARCH_REGS];
    logic [p_num_phys_regs-1:0] pending;
    logic [p_num_phys_regs-1:0] pending_next;
    logic [p_num_phys_regs-1:0] release_mask;
    logic [p_num_phys_regs-1:0] rebuild_mask;
    logic [p_num_alloc-1:0]     take;
    logic [PB-1:0]              offer_preg [p_num_alloc];
    logic [PB:0]                free_count;

    rename_free_list #(
        .p_num_regs  (p_num_phys_regs),
        .p_num_offer (p_num_alloc),
        .p_pb        (PB)
    ) u_free_list (
        .clk          (clk),
        .rst          (rst),
        .take         (take),
        .release_mask (release_mask),
        .squash       (squash),
        .rebuild_mask (rebuild_mask),
        .offer_preg   (offer_preg),
        .free_count   (free_count)
    );

    // Allocation ports in age order; each sees the map as updated by older
    // ports this cycle, so same-areg chains link ppreg to the previous preg.
    // areg 0 keeps its slot but neither consumes a preg nor remaps.
    always_comb begin
        spec_chain = spec_map;
        take       = '0;
        for (int k = 0; k < p_num_alloc; k++) begin
            alloc_rdy[k]   = (int'(free_count) > k) && !squash;
            alloc_preg[k]  = '0;
            alloc_ppreg[k] = '0;
            if (alloc_areg[k] != '0) begin
                alloc_preg[k]  = offer_preg[k];
                alloc_ppreg[k] = spec_chain[alloc_areg[k]];
                if (alloc_en[k] && alloc_rdy[k]) begin
                    spec_chain[alloc_areg[k]] = offer_preg[k];
                    take[k]                   = 1'b1;
                end
            end
        end
    end

    // Commits in port order update the committed map and release old pregs;
    // the squash rebuild frees everything the updated committed map does not hold.
    always_comb begin
        arch_next    = arch_map;
        release_mask = '0;
        for (int c = 0; c < p_num_commit; c++) begin
            if (commit_val[c] && commit_areg[c] != '0) begin
                arch_next[commit_areg[c]]  = commit_preg[c];
                release_mask[commit_ppreg[c]] = 1'b1;
            end
        end
        rebuild_mask = '1;
        for (int i = 0; i < ARCH_REGS; i++) rebuild_mask[arch_next[i]] = 1'b0;
    end

    // Pending bits: completions clear, then new allocations set (alloc wins).
    always_comb begin
        pending_next = pending;
        for (int c = 0; c < p_num_complete; c++) begin
            if (complete_val[c]) pending_next[complete_preg[c]] = 1'b0;
        end
        for (int k = 0; k < p_num_alloc; k++) begin
            if (take[k]) pending_next[offer_preg[k]] = 1'b1;
        end
    end

    // Lookups read registered state only; areg 0 is hard-wired to preg 0.
    always_comb begin
        for (int l = 0; l < p_num_lookup; l++) begin
            lookup_preg[l]    = '0;
            lookup_pending[l] = 1'b0;
            if (lookup_areg[l] != '0) begin
                lookup_preg[l]    = spec_map[lookup_areg[l]];
                lookup_pending[l] = pending[spec_map[lookup_areg[l]]];
`ifdef RENAME_TABLE_COMPLETE_BYPASS_EN
                for (int c = 0; c < p_num_complete; c++) begin
                    if (complete_val[c] && complete_preg[c] == spec_map[lookup_areg[l]])
                        lookup_pending[l] = 1'b0;
                end
`endif
            end
        end
    end

    // Map and pending registers; squash restores the speculative map from the
    // committed one (including this cycle's commits) and clears all pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_map[i] <= PB'(i);
                arch_map[i] <= PB'(i);
            end
            pending <= '0;
        end else begin
            arch_map <= arch_next;
            if (squash) begin
                spec_map <= arch_next;
                pending  <= '0;
            end else begin
                spec_map <= spec_chain;
                pending  <= pending_next;
            end
        end
    end

    // Caller-error checks: firing a not-ready port, or completing a preg that
    // is being allocated in the same cycle.
    for (genvar k = 0; k < p_num_alloc; k++) begin : g_alloc_chk
        a_alloc_needs_rdy: assert property (@(posedge clk) disable iff (!rst)
            (alloc_en[k] && !squash) |-> alloc_rdy[k]);
        for (genvar c = 0; c < p_num_complete; c++) begin : g_clash_chk
            a_no_complete_alloc_clash: assert property (@(posedge clk) disable iff (!rst)
                !(take[k] && complete_val[c] && complete_preg[c] == offer_preg[k]));
        end
    end

endmodule

// File: tb/tb_rename_table_multi.sv
// Directed bench for rename_table_multi (36 pregs, 2 alloc, 4 lookup,
// 2 complete, 2 commit ports).
module tb_rename_table_multi;
    import rename_pkg::*;

    localparam int NP = 36;
    localparam int NA = 2;
    localparam int NL = 4;
    localparam int NC = 2;
    localparam int NM = 2;
    localparam int PB = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    alloc_areg     [NA];
    logic          alloc_en       [NA];
    logic          alloc_rdy      [NA];
    logic [PB-1:0] alloc_preg     [NA];
    logic [PB-1:0] alloc_ppreg    [NA];
    logic [4:0]    lookup_areg    [NL];
    logic [PB-1:0] lookup_preg    [NL];
    logic          lookup_pending [NL];
    logic          complete_val   [NC];
    logic [PB-1:0] complete_preg  [NC];
    logic          commit_val     [NM];
    logic [4:0]    commit_areg    [NM];
    logic [PB-1:0] commit_preg    [NM];
    logic [PB-1:0] commit_ppreg   [NM];
    logic          squash;

    int tests = 0;
    int fails = 0;

    rename_table_multi #(
        .p_num_phys_regs (NP),
        .p_num_alloc     (NA),
        .p_num_lookup    (NL),
        .p_num_complete  (NC),
        .p_num_commit    (NM)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_areg     (alloc_areg),
        .alloc_en       (alloc_en),
        .alloc_rdy      (alloc_rdy),
        .alloc_preg     (alloc_preg),
        .alloc_ppreg    (alloc_ppreg),
        .lookup_areg    (lookup_areg),
        .lookup_preg    (lookup_preg),
        .lookup_pending (lookup_pending),
        .complete_val   (complete_val),
        .complete_preg  (complete_preg),
        .commit_val     (commit_val),
        .commit_areg    (commit_areg),
        .commit_preg    (commit_preg),
        .commit_ppreg   (commit_ppreg),
        .squash         (squash)
    );

    // Clock
    initial forever #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < NA; k++) begin alloc_areg[k] = '0; alloc_en[k] = 1'b0; end
        for (int l = 0; l < NL; l++) lookup_areg[l] = '0;
        for (int c = 0; c < NC; c++) begin complete_val[c] = 1'b0; complete_preg[c] = '0; end
        for (int c = 0; c < NM; c++) begin
            commit_val[c] = 1'b0; commit_areg[c] = '0; commit_preg[c] = '0; commit_ppreg[c] = '0;
        end
        squash = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic drive_alloc(input int k, input logic en, input int areg);
        alloc_en[k]   = en;
        alloc_areg[k] = 5'(areg);
    endtask

    task automatic drive_commit(input int c, input commit_msg_t m);
        commit_val[c]   = m.val;
        commit_areg[c]  = m.areg;
        commit_preg[c]  = m.preg;
        commit_ppreg[c] = m.ppreg;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int k = 0; k < NA; k++) begin
            tests++;
            if (alloc_rdy[k] !== 1'b1) begin
                fails++; $display("FAIL reset_rdy port=%0d got %0b want 1", k, alloc_rdy[k]);
            end
        end
        for (int base = 0; base < 32; base += NL) begin
            for (int l = 0; l < NL; l++) lookup_areg[l] = 5'(base + l);
            #1;
            for (int l = 0; l < NL; l++) begin
                tests++;
                if (lookup_preg[l] !== PB'(base + l) || lookup_pending[l] !== 1'b0) begin
                    fails++;
                    $display("FAIL reset_lookup areg=%0d got preg=%0d pend=%0b want preg=%0d pend=0",
                             base + l, lookup_preg[l], lookup_pending[l], base + l);
                end
            end
        end
    endtask

    task automatic test_same_areg_chain();
        do_reset();
        drive_alloc(0, 1'b1, 3);
        drive_alloc(1, 1'b1, 3);
        lookup_areg[0] = 5'd3;
        #1;
        tests++;
        if (alloc_preg[0] !== 6'd32 || alloc_ppreg[0] !== 6'd3) begin
            fails++; $display("FAIL chain_p0 got preg=%0d ppreg=%0d want 32/3", alloc_preg[0], alloc_ppreg[0]);
        end
        tests++;
        if (alloc_preg[1] !== 6'd33 || alloc_ppreg[1] !== 6'd32) begin
            fails++; $display("FAIL chain_p1 got preg=%0d ppreg=%0d want 33/32", alloc_preg[1], alloc_ppreg[1]);
        end
        tests++;
        if (lookup_preg[0] !== 6'd3 || lookup_pending[0] !== 1'b0) begin
            fails++; $display("FAIL chain_no_fwd got preg=%0d pend=%0b want 3/0", lookup_preg[0], lookup_pending[0]);
        end
        step();
        clear_inputs();
        lookup_areg[0] = 5'd3;
        #1;
        tests++;
        if (lookup_preg[0] !== 6'd33 || lookup_pending[0] !== 1'b1) begin
            fails++; $display("FAIL chain_lookup got preg=%0d pend=%0b want 33/1", lookup_preg[0], lookup_pending[0]);
        end
    endtask

    task automatic test_complete();
        logic exp_pend;
        exp_pend = 1'b1;
`ifdef RENAME_TABLE_COMPLETE_BYPASS_EN
        exp_pend = 1'b0;
`endif
        do_reset();
        drive_alloc(0, 1'b1, 1);
        step();
        clear_inputs();
        lookup_areg[1] = 5'd1;
        #1;
        tests++;
        if (lookup_preg[1] !== 6'd32 || lookup_pending[1] !== 1'b1) begin
            fails++; $display("FAIL cmpl_before got preg=%0d pend=%0b want 32/1", lookup_preg[1], lookup_pending[1]);
        end
        complete_val[1]  = 1'b1;
        complete_preg[1] = 6'd32;
        #1;
        tests++;
        if (lookup_pending[1] !== exp_pend) begin
            fails++; $display("FAIL cmpl_same_cycle got pend=%0b want %0b", lookup_pending[1], exp_pend);
        end
        step();
        complete_val[1] = 1'b0;
        #1;
        tests++;
        if (lookup_preg[1] !== 6'd32 || lookup_pending[1] !== 1'b0) begin
            fails++; $display("FAIL cmpl_after got preg=%0d pend=%0b want 32/0", lookup_preg[1], lookup_pending[1]);
        end
    endtask

    task automatic test_drain_and_free();
        commit_msg_t m;
        do_reset();
        drive_alloc(0, 1'b1, 1);
        drive_alloc(1, 1'b1, 2);
        step();
        drive_alloc(0, 1'b1, 3);
        drive_alloc(1, 1'b1, 4);
        #1;
        tests++;
        if (alloc_preg[0] !== 6'd34 || alloc_preg[1] !== 6'd35) begin
            fails++; $display("FAIL drain_offers got %0d,%0d want 34,35", alloc_preg[0], alloc_preg[1]);
        end
        step();
        clear_inputs();
        #1;
        tests++;
        if (alloc_rdy[0] !== 1'b0 || alloc_rdy[1] !== 1'b0) begin
            fails++; $display("FAIL drain_empty got rdy=%0b%0b want 00", alloc_rdy[0], alloc_rdy[1]);
        end
        m = '{val: 1'b1, areg: 5'd1, preg: 6'd32, ppreg: 6'd1};
        drive_commit(0, m);
        #1;
        tests++;
        if (alloc_rdy[0] !== 1'b0) begin
            fails++; $display("FAIL free_not_same_cycle got rdy0=%0b want 0", alloc_rdy[0]);
        end
        step();
        clear_inputs();
        drive_alloc(0, 1'b1, 7);
        #1;
        tests++;
        if (alloc_rdy[0] !== 1'b1 || alloc_rdy[1] !== 1'b0) begin
            fails++; $display("FAIL free_rdy got rdy=%0b%0b want 10", alloc_rdy[0], alloc_rdy[1]);
        end
        tests++;
        if (alloc_preg[0] !== 6'd1 || alloc_ppreg[0] !== 6'd7) begin
            fails++; $display("FAIL free_realloc got preg=%0d ppreg=%0d want 1/7", alloc_preg[0], alloc_ppreg[0]);
        end
        step();
        clear_inputs();
        lookup_areg[2] = 5'd7;
        #1;
        tests++;
        if (lookup_preg[2] !== 6'd1 || lookup_pending[2] !== 1'b1 || alloc_rdy[0] !== 1'b0) begin
            fails++; $display("FAIL realloc_lookup got preg=%0d pend=%0b rdy0=%0b want 1/1/0",
                              lookup_preg[2], lookup_pending[2], alloc_rdy[0]);
        end
    endtask

    task automatic test_squash();
        commit_msg_t m;
        do_reset();
        drive_alloc(0, 1'b1, 5);
        drive_alloc(1, 1'b1, 6);
        step();
        clear_inputs();
        m = '{val: 1'b1, areg: 5'd5, preg: 6'd32, ppreg: 6'd5};
        drive_commit(0, m);
        step();
        clear_inputs();
        squash = 1'b1;
        drive_alloc(0, 1'b1, 9);
        drive_alloc(1, 1'b1, 10);
        #1;
        tests++;
        if (alloc_rdy[0] !== 1'b0 || alloc_rdy[1] !== 1'b0) begin
            fails++; $display("FAIL squash_rdy got rdy=%0b%0b want 00", alloc_rdy[0], alloc_rdy[1]);
        end
        step();
        clear_inputs();
        lookup_areg[0] = 5'd5;
        lookup_areg[1] = 5'd6;
        lookup_areg[2] = 5'd9;
        drive_alloc(0, 1'b0, 10);
        drive_alloc(1, 1'b0, 11);
        #1;
        tests++;
        if (lookup_preg[0] !== 6'd32 || lookup_pending[0] !== 1'b0) begin
            fails++; $display("FAIL squash_l5 got preg=%0d pend=%0b want 32/0", lookup_preg[0], lookup_pending[0]);
        end
        tests++;
        if (lookup_preg[1] !== 6'd6 || lookup_pending[1] !== 1'b0) begin
            fails++; $display("FAIL squash_l6 got preg=%0d pend=%0b want 6/0", lookup_preg[1], lookup_pending[1]);
        end
        tests++;
        if (lookup_preg[2] !== 6'd9) begin
            fails++; $display("FAIL squash_l9 got preg=%0d want 9", lookup_preg[2]);
        end
        tests++;
        if (alloc_rdy[0] !== 1'b1 || alloc_rdy[1] !== 1'b1 || alloc_preg[0] !== 6'd5 || alloc_preg[1] !== 6'd33) begin
            fails++; $display("FAIL squash_free_lo got rdy=%0b%0b offers=%0d,%0d want 11 5,33",
                              alloc_rdy[0], alloc_rdy[1], alloc_preg[0], alloc_preg[1]);
        end
        drive_alloc(0, 1'b1, 10);
        drive_alloc(1, 1'b1, 11);
        step();
        drive_alloc(0, 1'b1, 12);
        drive_alloc(1, 1'b1, 13);
        #1;
        tests++;
        if (alloc_preg[0] !== 6'd34 || alloc_preg[1] !== 6'd35) begin
            fails++; $display("FAIL squash_free_hi got offers=%0d,%0d want 34,35", alloc_preg[0], alloc_preg[1]);
        end
        step();
        clear_inputs();
        #1;
        tests++;
        if (alloc_rdy[0] !== 1'b0) begin
            fails++; $display("FAIL squash_free_count got rdy0=%0b want 0", alloc_rdy[0]);
        end
    endtask

    task automatic test_commit_with_squash();
        commit_msg_t m;
        do_reset();
        drive_alloc(0, 1'b1, 8);
        step();
        clear_inputs();
        m = '{val: 1'b1, areg: 5'd8, preg: 6'd32, ppreg: 6'd8};
        drive_commit(1, m);
        squash = 1'b1;
        step();
        clear_inputs();
        lookup_areg[3] = 5'd8;
        drive_alloc(0, 1'b0, 1);
        drive_alloc(1, 1'b0, 2);
        #1;
        tests++;
        if (lookup_preg[3] !== 6'd32 || lookup_pending[3] !== 1'b0) begin
            fails++; $display("FAIL csq_lookup got preg=%0d pend=%0b want 32/0", lookup_preg[3], lookup_pending[3]);
        end
        tests++;
        if (alloc_preg[0] !== 6'd8 || alloc_preg[1] !== 6'd33) begin
            fails++; $display("FAIL csq_free got offers=%0d,%0d want 8,33", alloc_preg[0], alloc_preg[1]);
        end
    endtask

    task automatic test_reset_during_squash();
        do_reset();
        drive_alloc(0, 1'b1, 3);
        drive_alloc(1, 1'b1, 3);
        step();
        squash = 1'b1;
        drive_alloc(0, 1'b1, 4);
        drive_alloc(1, 1'b1, 5);
        rst = 1'b0;
        step();
        rst = 1'b1;
        clear_inputs();
        lookup_areg[0] = 5'd3;
        lookup_areg[1] = 5'd4;
        lookup_areg[2] = 5'd5;
        lookup_areg[3] = 5'd0;
        #1;
        tests++;
        if (lookup_preg[0] !== 6'd3 || lookup_pending[0] !== 1'b0 || lookup_preg[1] !== 6'd4 ||
            lookup_preg[2] !== 6'd5 || lookup_preg[3] !== 6'd0 || lookup_pending[3] !== 1'b0) begin
            fails++; $display("FAIL rst_sq_map got %0d/%0b %0d %0d %0d/%0b want 3/0 4 5 0/0",
                              lookup_preg[0], lookup_pending[0], lookup_preg[1], lookup_preg[2],
                              lookup_preg[3], lookup_pending[3]);
        end
        tests++;
        if (alloc_rdy[0] !== 1'b1 || alloc_rdy[1] !== 1'b1) begin
            fails++; $display("FAIL rst_sq_rdy got rdy=%0b%0b want 11", alloc_rdy[0], alloc_rdy[1]);
        end
        drive_alloc(0, 1'b1, 0);
        drive_alloc(1, 1'b1, 4);
        #1;
        tests++;
        if (alloc_preg[0] !== 6'd0 || alloc_ppreg[0] !== 6'd0) begin
            fails++; $display("FAIL areg0_alloc got preg=%0d ppreg=%0d want 0/0", alloc_preg[0], alloc_ppreg[0]);
        end
        tests++;
        if (alloc_preg[1] !== 6'd33 || alloc_ppreg[1] !== 6'd4) begin
            fails++; $display("FAIL areg0_slot got preg=%0d ppreg=%0d want 33/4", alloc_preg[1], alloc_ppreg[1]);
        end
        step();
        clear_inputs();
        drive_alloc(0, 1'b0, 1);
        drive_alloc(1, 1'b0, 2);
        lookup_areg[0] = 5'd4;
        lookup_areg[1] = 5'd0;
        #1;
        tests++;
        if (alloc_preg[0] !== 6'd32 || alloc_preg[1] !== 6'd34) begin
            fails++; $display("FAIL areg0_nofree got offers=%0d,%0d want 32,34", alloc_preg[0], alloc_preg[1]);
        end
        tests++;
        if (lookup_preg[0] !== 6'd33 || lookup_pending[0] !== 1'b1 ||
            lookup_preg[1] !== 6'd0 || lookup_pending[1] !== 1'b0) begin
            fails++; $display("FAIL areg0_lookup got %0d/%0b %0d/%0b want 33/1 0/0",
                              lookup_preg[0], lookup_pending[0], lookup_preg[1], lookup_pending[1]);
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_same_areg_chain();
        test_complete();
        test_drain_and_free();
        test_squash();
        test_commit_with_squash();
        test_reset_during_squash();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
